// File: rtl/dmem_arbiter.sv
// Arbitrates the single data-memory port between the MIPS load/store path and an
// auxiliary requester; CPU has priority, a bounded wait counter keeps aux from starving.
module dmem_arbiter #(
   parameter int unsigned Abits        = 32,
   parameter int unsigned Dbits        = 32,
   parameter int unsigned AUX_WAIT_MAX = 3
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             run,
   output logic             enable,
   input  logic             cpu_rd,
   input  logic             cpu_wr,
   input  logic [Abits-1:0] cpu_addr,
   input  logic [Dbits-1:0] cpu_wdata,
   output logic [Dbits-1:0] cpu_rdata,
   input  logic             aux_req,
   input  logic             aux_wr,
   input  logic [Abits-1:0] aux_addr,
   input  logic [Dbits-1:0] aux_wdata,
   output logic             aux_gnt,
   output logic             aux_rvalid,
   output logic [Dbits-1:0] aux_rdata,
   output logic [Abits-1:0] mem_addr,
   output logic             mem_wr,
   output logic [Dbits-1:0] mem_wdata,
   input  logic [Dbits-1:0] mem_rdata
);

   localparam int unsigned CntW = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CPU_RD = 2'd1,
      AUX_RD = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
   logic            cpu_req;
   logic            can_issue;
   logic            wait_full;
   logic            aux_win;
   logic            cpu_win;
   logic            stall;

   // Arbitration: CPU first, unless aux has already waited its full budget.
   assign cpu_req   = run & (cpu_rd | cpu_wr);
   assign can_issue = (state_q != CPU_RD);
   assign wait_full = (wait_cnt_q == CntW'(AUX_WAIT_MAX));
   assign aux_win   = can_issue & aux_req & (~cpu_req | wait_full);
   assign cpu_win   = can_issue & cpu_req & ~aux_win;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // Next state; cpu_wr dominates cpu_rd so a simultaneous rd/wr is a store.
   always_comb begin
      state_d    = IDLE;
      wait_cnt_d = '0;
      if (aux_win) begin
         if (aux_wr) state_d = IDLE;
         else        state_d = AUX_RD;
      end else if (cpu_win && !cpu_wr) begin
         state_d = CPU_RD;
      end
      if (aux_req && !aux_win) begin
         wait_cnt_d = wait_full ? wait_cnt_q : wait_cnt_q + CntW'(1);
      end
   end

   // Outputs; strobes are forced low while reset is held.
   always_comb begin
      stall      = cpu_req & (aux_win | (cpu_win & ~cpu_wr));
      enable     = reset & run & ~stall;
      aux_gnt    = reset & aux_win;
      aux_rvalid = reset & (state_q == AUX_RD);
      mem_wr     = reset & (aux_win ? aux_wr : (cpu_win & cpu_wr));
      mem_addr   = aux_win ? aux_addr : cpu_addr;
      mem_wdata  = aux_win ? aux_wdata : cpu_wdata;
      cpu_rdata  = mem_rdata;
      aux_rdata  = mem_rdata;
   end

endmodule
